// File: rtl/ovl_rd_responder.sv
// ============================================================================
// Module   : ovl_rd_responder
// Brief    : FIFO-backed responder for the four-phase rd/rd_ack handshake.
//            Optional macro OVL_RD_RESP_ERR_INJECT_EN adds err_inject, which
//            flips data[0] once per transaction to break window stability.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ovl_rd_responder #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int ACK_LAT = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       rd,
    output logic                       rd_ack,
    output logic [WIDTH-1:0]           data,
    output logic                       underflow,
    output logic                       overflow,
    output logic                       aborted
`ifdef OVL_RD_RESP_ERR_INJECT_EN
    ,
    input  logic                       err_inject
`endif
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_LAT_W = $clog2(ACK_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_overflow;

    state_t             r_state;
    logic [c_LAT_W-1:0] r_lat_cnt;
    logic               r_rd_ack;
    logic [WIDTH-1:0]   r_data;
    logic               r_underflow;
    logic               r_aborted;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == S_IDLE) && rd && !w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push  = wr_en && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && !w_push;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef OVL_RD_RESP_ERR_INJECT_EN
    logic r_inj_done;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_rd_ack    <= 1'b0;
            r_data      <= '0;
            r_underflow <= 1'b0;
            r_aborted   <= 1'b0;
`ifdef OVL_RD_RESP_ERR_INJECT_EN
            r_inj_done  <= 1'b0;
`endif
        end else begin
            r_underflow <= 1'b0;
            r_aborted   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd) begin
                        if (w_empty) begin
                            r_underflow <= 1'b1;
                        end else begin
                            r_data <= r_mem[r_rd_ptr];
                        end
                        r_lat_cnt <= c_LAT_W'(ACK_LAT);
                        r_state   <= S_WAIT;
`ifdef OVL_RD_RESP_ERR_INJECT_EN
                        r_inj_done <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    if (!rd) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (r_lat_cnt == c_LAT_W'(1)) begin
                        r_rd_ack <= 1'b1;
                        r_state  <= S_ACK;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
`ifdef OVL_RD_RESP_ERR_INJECT_EN
                    if (err_inject && !r_inj_done) begin
                        r_data[0]  <= ~r_data[0];
                        r_inj_done <= 1'b1;
                    end
`endif
                end
                S_ACK: begin
                    if (!rd) begin
                        r_rd_ack <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rd_ack <= 1'b0;
                end
            endcase
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign rd_ack    = r_rd_ack;
    assign data      = r_data;
    assign underflow = r_underflow;
    assign overflow  = r_overflow;
    assign aborted   = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_ovl_rd_responder.sv
// ============================================================================
// Module   : tb_ovl_rd_responder
// Brief    : Scoreboard bench for ovl_rd_responder (WIDTH=4, DEPTH=4, ACK_LAT=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ovl_rd_responder;

    localparam int c_WIDTH = 4;
    localparam int c_DEPTH = 4;
    localparam int c_LAT   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = '0;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       rd = 1'b0;
    logic       rd_ack;
    logic [3:0] data;
    logic       underflow;
    logic       overflow;
    logic       aborted;
`ifdef OVL_RD_RESP_ERR_INJECT_EN
    logic       err_inject = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] sb [$];
    logic [3:0] exp_d;
    logic [3:0] last_d;

    ovl_rd_responder #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .ACK_LAT(c_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .rd        (rd),
        .rd_ack    (rd_ack),
        .data      (data),
        .underflow (underflow),
        .overflow  (overflow),
        .aborted   (aborted)
`ifdef OVL_RD_RESP_ERR_INJECT_EN
        ,
        .err_inject(err_inject)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        if (sb.size() < c_DEPTH) sb.push_back(v);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (rd_ack !== 1'b0) begin n_err++; $display("FAIL reset_rd_ack got %b want 0", rd_ack); end
        n_cmp++; if (data !== 4'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", empty, full); end
        n_cmp++; if ({underflow, overflow, aborted} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {underflow, overflow, aborted}); end
        sb.delete();
    endtask

    task automatic test_basic();
        push_word(4'hF);
        n_cmp++; if (count !== 3'd1 || empty !== 1'b0) begin n_err++; $display("FAIL basic_count got %0d e=%b want 1 e=0", count, empty); end
        rd = 1'b1;
        tick();
        exp_d = sb.pop_front();
        n_cmp++; if (data !== exp_d) begin n_err++; $display("FAIL basic_data got %h want %h", data, exp_d); end
        for (int i = 1; i <= c_LAT; i++) begin
            tick();
            n_cmp++;
            if (rd_ack !== (i == c_LAT) || data !== exp_d) begin
                n_err++;
                $display("FAIL basic_lat cyc %0d got ack=%b d=%h want ack=%b d=%h", i, rd_ack, data, (i == c_LAT), exp_d);
            end
        end
        rd = 1'b0;
        tick();
        n_cmp++; if (rd_ack !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL basic_release got ack=%b e=%b want 0 1", rd_ack, empty); end
    endtask

    task automatic test_fill_overflow();
        bit got_ack;
        wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_data = 4'(i);
            if (sb.size() < c_DEPTH) sb.push_back(4'(i));
            tick();
            if (i == 4) begin
                n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL fill_full got f=%b ov=%b want 1 0", full, overflow); end
            end
            if (i == 5) begin
                n_cmp++; if (overflow !== 1'b1 || count !== 3'd4) begin n_err++; $display("FAIL fill_overflow got ov=%b cnt=%0d want 1 4", overflow, count); end
            end
        end
        wr_en = 1'b0;
        tick();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ov_pulse got %b want 0", overflow); end
        for (int r = 0; r < 4; r++) begin
            rd = 1'b1;
            tick();
            exp_d = sb.pop_front();
            n_cmp++; if (data !== exp_d) begin n_err++; $display("FAIL fill_read%0d got %h want %h", r, data, exp_d); end
            got_ack = 1'b0;
            for (int k = 0; k < 20 && !got_ack; k++) begin
                tick();
                got_ack = rd_ack;
            end
            n_cmp++; if (!got_ack) begin n_err++; $display("FAIL fill_ack%0d got timeout want ack", r); end
            rd = 1'b0;
            tick();
        end
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL fill_drain got cnt=%0d want 0", count); end
    endtask

    task automatic test_underflow();
        push_word(4'hC);
        rd = 1'b1;
        tick();
        last_d = sb.pop_front();
        for (int k = 0; k < 20 && !rd_ack; k++) tick();
        rd = 1'b0;
        tick();
        rd = 1'b1;
        tick();
        n_cmp++; if (underflow !== 1'b1 || data !== last_d) begin n_err++; $display("FAIL under_pulse got uf=%b d=%h want 1 %h", underflow, data, last_d); end
        for (int i = 1; i <= c_LAT; i++) begin
            tick();
            n_cmp++;
            if (rd_ack !== (i == c_LAT) || underflow !== 1'b0 || data !== last_d) begin
                n_err++;
                $display("FAIL under_lat cyc %0d got ack=%b uf=%b d=%h want ack=%b uf=0 d=%h", i, rd_ack, underflow, data, (i == c_LAT), last_d);
            end
        end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bit saw_ack;
        push_word(4'hA);
        push_word(4'hB);
        rd = 1'b1;
        tick();
        exp_d = sb.pop_front();
        n_cmp++; if (data !== exp_d) begin n_err++; $display("FAIL abort_data got %h want %h", data, exp_d); end
        tick();
        rd = 1'b0;
        tick();
        n_cmp++; if (aborted !== 1'b1 || rd_ack !== 1'b0) begin n_err++; $display("FAIL abort_pulse got ab=%b ack=%b want 1 0", aborted, rd_ack); end
        saw_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            saw_ack = saw_ack | rd_ack;
        end
        n_cmp++; if (aborted !== 1'b0 || saw_ack) begin n_err++; $display("FAIL abort_after got ab=%b ack_seen=%b want 0 0", aborted, saw_ack); end
        rd = 1'b1;
        tick();
        exp_d = sb.pop_front();
        n_cmp++; if (data !== exp_d) begin n_err++; $display("FAIL abort_next got %h want %h", data, exp_d); end
        for (int k = 0; k < 20 && !rd_ack; k++) tick();
        n_cmp++; if (rd_ack !== 1'b1) begin n_err++; $display("FAIL abort_next_ack got %b want 1", rd_ack); end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        push_word(4'h7);
        push_word(4'h8);
        rd = 1'b1;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (rd_ack !== 1'b0 || data !== 4'h0 || count !== 3'd0 || empty !== 1'b1 || {underflow, overflow, aborted} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_wait got ack=%b d=%h cnt=%0d e=%b want 0 0 0 1", rd_ack, data, count, empty);
        end
        rd = 1'b0;
        tick();
        reset = 1'b0;
        sb.delete();
        tick();
        push_word(4'h9);
        rd = 1'b1;
        tick();
        for (int k = 0; k < 20 && !rd_ack; k++) tick();
        n_cmp++; if (rd_ack !== 1'b1 || data !== 4'h9) begin n_err++; $display("FAIL rst_pre_ack got ack=%b d=%h want 1 9", rd_ack, data); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (rd_ack !== 1'b0 || data !== 4'h0 || count !== 3'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ack got ack=%b d=%h cnt=%0d want 0 0 0", rd_ack, data, count);
        end
        rd = 1'b0;
        tick();
        reset = 1'b0;
        sb.delete();
        tick();
    endtask

    task automatic test_err_inject();
        bit stable;
        push_word(4'hC);
        rd = 1'b1;
        tick();
        exp_d = sb.pop_front();
`ifdef OVL_RD_RESP_ERR_INJECT_EN
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        exp_d = exp_d ^ 4'h1;
        n_cmp++; if (data !== exp_d) begin n_err++; $display("FAIL inj_flip got %h want %h", data, exp_d); end
`endif
        stable = 1'b1;
        for (int k = 0; k < 20 && !rd_ack; k++) begin
            tick();
            if (data !== exp_d) stable = 1'b0;
        end
        rd = 1'b0;
        tick();
        n_cmp++; if (!stable || data !== exp_d) begin n_err++; $display("FAIL inj_window got d=%h stable=%b want %h 1", data, stable, exp_d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_underflow();
        test_abort();
        test_reset_mid();
        test_err_inject();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ovl_rd_responder.md
# ovl_rd_responder

Read-side responder for the four-phase `rd`/`rd_ack` handshake exercised by the OVL window checkers. It buffers words loaded by the bench in a small FIFO. It answers each `rd` request by presenting one word on `data`, holding it stable for the whole request window, and asserting `rd_ack` after a fixed latency. It sits opposite the bench requester and is the DUT-side stimulus source for `ovl_win_unchange` pass and fail tests.

## Interface
- `WIDTH`, 4 — data word width.
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `ACK_LAT`, 5 — cycles from `rd` sampled high (in IDLE) to `rd_ack` rising; ≥1.

Ports:
- `clk` in 1 — single clock; all logic on posedge.
- `reset` in 1 — asynchronous, active-high reset.
- `wr_en` in 1 — push `wr_data` into the FIFO.
- `wr_data` in WIDTH — word to push.
- `full` out 1 — FIFO holds DEPTH words.
- `empty` out 1 — FIFO holds 0 words.
- `count` out $clog2(DEPTH)+1 — occupancy.
- `rd` in 1 — read request (start event); level, four-phase.
- `rd_ack` out 1 — acknowledge (end event).
- `data` out WIDTH — response word; stable from load until `rd_ack` falls.
- `underflow` out 1 — one-cycle pulse: request accepted while FIFO was empty.
- `overflow` out 1 — one-cycle pulse: push dropped because FIFO full.
- `aborted` out 1 — one-cycle pulse: `rd` dropped before `rd_ack`.
- `err_inject` in 1 — present only with `OVL_RD_RESP_ERR_INJECT_EN`.

## Operation
- Reset values: `rd_ack`=0, `data`=0, `underflow`=`overflow`=`aborted`=0, `count`=0, `empty`=1, `full`=0, FSM=IDLE, pointers=0.
- FIFO: circular buffer with wrap-around pointers.
  - Push when `wr_en` and not full. Push when full raises `overflow` and leaves the buffer unchanged.
  - Push and pop in the same cycle: when full, both succeed and `count` is unchanged. When empty, the pop sees empty (the pushed word is not bypassed).
- FSM states:
  - IDLE:
    - On `rd`=1, pop the head into `data`, load the latency counter with ACK_LAT, and go to WAIT.
    - If the FIFO is empty, `data` keeps its previous value, `underflow` pulses, and the transaction proceeds normally.
  - WAIT:
    - Counter decrements each cycle.
    - On the cycle the counter reaches 1, set `rd_ack`=1 and go to ACK.
    - If `rd`=0 in WAIT, go to IDLE with no ack and pulse `aborted`.
  - ACK:
    - Hold `rd_ack`=1 and `data` until `rd`=0.
    - On `rd`=0, clear `rd_ack` and go to IDLE.
- `data` never changes in WAIT or ACK, except via error injection.
- A new request requires `rd` to return to 0. `rd` held high across IDLE re-entry is impossible, because ACK exits only on `rd`=0.
- Reset asserted mid-transaction clears everything immediately. No ack and no pulses are produced for the killed transaction, and FIFO contents are lost.

## Timing
- `rd` sampled high at posedge N (IDLE) → `data` valid after edge N.
- `rd_ack` is 1 after edge N+ACK_LAT.
- `rd` sampled 0 at edge M in ACK → `rd_ack` is 0 after edge M. The earliest next accept is edge M+1.
- Status pulses are registered, last exactly one cycle, and align with the causing edge.
- `full`/`empty`/`count` update one edge after the push/pop.

## Configuration
- `OVL_RD_RESP_ERR_INJECT_EN` defined:
  - The `err_inject` port exists.
  - `err_inject`=1 sampled in WAIT inverts `data[0]`, at most once per transaction.
  - This deliberately violates window stability, for fail tests.
- Undefined: the port is absent, and `data` is guaranteed stable across every window.

## Test plan
- Reset, push 4'hF, `rd`=1 at edge 10 → `data`=F after edge 10, `rd_ack`=1 after edge 15. Drop `rd` → `rd_ack`=0 next edge, `empty`=1.
- Push 1,2,3,4,5 back-to-back (DEPTH=4) → `full`=1 after 4th push, `overflow` pulses on 5th. Four reads return 1,2,3,4; `count` reaches 0.
- `rd` with FIFO empty after prior word C → `underflow` pulses, `data` stays C, and `rd_ack` still rises after 5 cycles.
- `rd` drops 2 cycles after accept → `aborted` pulses, `rd_ack` never rises, FSM returns to IDLE, and the next `rd` pops the following word.
- Reset asserted in WAIT and in ACK → all outputs return to reset values within the same cycle, and `count`=0.
- With `OVL_RD_RESP_ERR_INJECT_EN`, data 4'hC and `err_inject` pulsed in WAIT → `data`=D until `rd_ack` falls, and the `ovl_win_unchange` instance fires. Without the macro, the same sequence gives no checker fire.
